// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge-detection pipeline.
package sobel_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned COEF_R       = 77;
    localparam int unsigned COEF_G       = 150;
    localparam int unsigned COEF_B       = 29;
    localparam int unsigned GRAD_W       = 11;
    localparam int unsigned MAG_MAX      = 255;
    localparam int unsigned PIPE_LATENCY = 4;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of gray pixels as a shift FIFO; dout_o is the pixel pushed DEPTH shifts ago.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic shift_en_i,
    input  pix_t din_i,
    output pix_t dout_o
);

    // Contents are deliberately not reset; the row counter upstream gates validity.
    pix_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_top.sv
// Streaming 3x3 Sobel edge detector: RGB -> gray -> window -> |Gx|+|Gy| -> threshold.
module sobel_top
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 8,
    parameter int unsigned THRESHOLD = 64
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        rgb_enable,
    input  logic [23:0] rgb_data_in,
    output logic [23:0] sobel_data_out,
    output logic [7:0]  sobel_mag,
    output logic        sobel_valid
);

    localparam int unsigned      COL_W    = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    function automatic pix_t rgb_to_gray(input logic [23:0] rgb);
        logic [15:0] acc;
        acc = 16'(COEF_R * 32'(rgb[23:16]) + COEF_G * 32'(rgb[15:8]) + COEF_B * 32'(rgb[7:0]));
        return pix_t'(acc >> 8);
    endfunction

    function automatic grad_t tap121(input pix_t a, input pix_t b, input pix_t c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    function automatic logic [GRAD_W-2:0] abs_grad(input grad_t g);
        grad_t n;
        n = g[GRAD_W-1] ? -g : g;
        return (GRAD_W-1)'(n);
    endfunction

    function automatic pix_t sat_mag(input logic [GRAD_W-1:0] sum);
        return (sum > GRAD_W'(MAG_MAX)) ? pix_t'(MAG_MAX) : pix_t'(sum);
    endfunction

    logic [COL_W-1:0] col_q, col_d, col_p1_q;
    logic [1:0]       row_q, row_d, row_p1_q;
    pix_t             gray_p1_q;
    logic             vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    pix_t             win_q [3][3];
    pix_t             l1_out, l2_out;
    grad_t            gx_d, gy_d, gx_p3_q, gy_p3_q;
    pix_t             mag_d, mag_p4_q;
    logic             win_complete;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (rgb_enable) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q != 2'd2) row_d = row_q + 2'd1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Stage 1: gray conversion, pixel position tagging, raster counters
    always_ff @(posedge clk or negedge rst_p) begin
        if (!rst_p) begin
            col_q     <= '0;
            row_q     <= '0;
            vld_p1_q  <= 1'b0;
            gray_p1_q <= '0;
            col_p1_q  <= '0;
            row_p1_q  <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            vld_p1_q <= rgb_enable;
            if (rgb_enable) begin
                gray_p1_q <= rgb_to_gray(rgb_data_in);
                col_p1_q  <= col_q;
                row_p1_q  <= row_q;
            end
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
        .clk        (clk),
        .shift_en_i (vld_p1_q),
        .din_i      (gray_p1_q),
        .dout_o     (l1_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line2 (
        .clk        (clk),
        .shift_en_i (vld_p1_q),
        .din_i      (l1_out),
        .dout_o     (l2_out)
    );

    assign win_complete = (row_p1_q == 2'd2) && (col_p1_q >= COL_W'(2));

    // Stage 2: 3x3 window shift; row 0 is the oldest line
    always_ff @(posedge clk or negedge rst_p) begin
        if (!rst_p) begin
            vld_p2_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            vld_p2_q <= vld_p1_q && win_complete;
            if (vld_p1_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= l2_out;
                win_q[1][2] <= l1_out;
                win_q[2][2] <= gray_p1_q;
            end
        end
    end

    assign gx_d = tap121(win_q[0][2], win_q[1][2], win_q[2][2])
                - tap121(win_q[0][0], win_q[1][0], win_q[2][0]);
    assign gy_d = tap121(win_q[2][0], win_q[2][1], win_q[2][2])
                - tap121(win_q[0][0], win_q[0][1], win_q[0][2]);

    // Stage 3: gradients
    always_ff @(posedge clk or negedge rst_p) begin
        if (!rst_p) begin
            vld_p3_q <= 1'b0;
            gx_p3_q  <= '0;
            gy_p3_q  <= '0;
        end else begin
            vld_p3_q <= vld_p2_q;
            gx_p3_q  <= gx_d;
            gy_p3_q  <= gy_d;
        end
    end

    assign mag_d = sat_mag({1'b0, abs_grad(gx_p3_q)} + {1'b0, abs_grad(gy_p3_q)});

    // Stage 4: clamped magnitude
    always_ff @(posedge clk or negedge rst_p) begin
        if (!rst_p) begin
            vld_p4_q <= 1'b0;
            mag_p4_q <= '0;
        end else begin
            vld_p4_q <= vld_p3_q;
            mag_p4_q <= mag_d;
        end
    end

    // Stage 5: outputs hold their last value across bubbles
    always_ff @(posedge clk or negedge rst_p) begin
        if (!rst_p) begin
            sobel_valid    <= 1'b0;
            sobel_mag      <= '0;
            sobel_data_out <= '0;
        end else begin
            sobel_valid <= vld_p4_q;
            if (vld_p4_q) begin
                sobel_mag      <= mag_p4_q;
                sobel_data_out <= (32'(mag_p4_q) >= THRESHOLD) ? 24'hFFFFFF : 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_sobel_top.sv
// Scoreboard bench for sobel_top: stimulus queues expected outputs with their due cycle; a monitor checks them.
module tb_sobel_top;
    import sobel_pkg::*;

    localparam int W   = 8;
    localparam int THR = 64;

    localparam int K_WHITE = 0;
    localparam int K_HALF  = 1;
    localparam int K_TOPW  = 2;
    localparam int K_R16   = 3;
    localparam int K_R8    = 4;
    localparam int K_R7    = 5;

    logic        clk = 1'b0;
    logic        rst_p = 1'b0;
    logic        rgb_enable = 1'b0;
    logic [23:0] rgb_data_in = '0;
    logic [23:0] sobel_data_out;
    logic [7:0]  sobel_mag;
    logic        sobel_valid;

    sobel_top #(.IMG_WIDTH(W), .THRESHOLD(THR)) dut (
        .clk            (clk),
        .rst_p          (rst_p),
        .rgb_enable     (rgb_enable),
        .rgb_data_in    (rgb_data_in),
        .sobel_data_out (sobel_data_out),
        .sobel_mag      (sobel_mag),
        .sobel_valid    (sobel_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          mag;
        logic [23:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  last_mag = '0;
    logic [23:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int kind, input int r, input int c);
        logic [7:0] g;
        case (kind)
            K_WHITE: g = 8'hFF;
            K_HALF:  g = (c < 4) ? 8'hFF : 8'h00;
            K_TOPW:  g = (r == 0) ? 8'hFF : 8'h00;
            K_R16:   g = 8'(16 * c);
            K_R8:    g = 8'(8 * c);
            default: g = 8'(7 * c);
        endcase
        return {g, g, g};
    endfunction

    // Hand-computed magnitudes for a complete window whose newest column is c.
    function automatic int exp_mag(input int kind, input int c);
        case (kind)
            K_WHITE: return 0;
            K_HALF:  return (c == 4 || c == 5) ? 255 : 0;
            K_TOPW:  return 255;
            K_R16:   return 128;
            K_R8:    return 64;
            default: return 56;
        endcase
    endfunction

    task automatic px(input logic [23:0] rgb, input int m);
        exp_t e;
        @(negedge clk);
        rgb_enable  = 1'b1;
        rgb_data_in = rgb;
        if (m >= 0) begin
            e.mag  = m;
            e.data = (m >= THR) ? 24'hFFFFFF : 24'h000000;
            e.due  = cyc + int'(PIPE_LATENCY) + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rgb_enable  = 1'b0;
            rgb_data_in = 24'($urandom);
        end
    endtask

    task automatic run_frame(input int kind, input int rows, input int extra, input bit gaps);
        int nrows;
        int ncols;
        nrows = (extra > 0) ? rows + 1 : rows;
        for (int r = 0; r < nrows; r++) begin
            ncols = (r == rows) ? extra : W;
            for (int c = 0; c < ncols; c++) begin
                px(pix(kind, r, c), (r >= 2 && c >= 2) ? exp_mag(kind, c) : -1);
                if (gaps) idle(1);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rgb_enable = 1'b0;
        rst_p      = 1'b0;
        q.delete();
        last_mag  = '0;
        last_data = '0;
        #1;
        check("rst_valid", 32'(sobel_valid), 32'd0);
        check("rst_mag",   32'(sobel_mag), 32'd0);
        check("rst_data",  32'(sobel_data_out), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_p = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_p) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_output got=none want_mag=%0d due=%0d cyc=%0d", q[0].mag, q[0].due, cyc);
                void'(q.pop_front());
            end
            if (sobel_valid) begin
                if (q.size() == 0 || q[0].due != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid got_mag=%0d cyc=%0d want=no_output_now", sobel_mag, cyc);
                end else begin
                    e = q.pop_front();
                    check("out_mag",  32'(sobel_mag), 32'(e.mag));
                    check("out_data", 32'(sobel_data_out), 32'(e.data));
                end
                last_mag  = sobel_mag;
                last_data = sobel_data_out;
            end else begin
                check("hold_mag",  32'(sobel_mag), 32'(last_mag));
                check("hold_data", 32'(sobel_data_out), 32'(last_data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        run_frame(K_WHITE, 3, 0, 1'b0);
        idle(8);

        do_reset();
        run_frame(K_HALF, 4, 0, 1'b0);
        idle(8);

        do_reset();
        run_frame(K_TOPW, 3, 0, 1'b0);
        idle(8);

        do_reset();
        run_frame(K_HALF, 3, 0, 1'b1);
        idle(8);

        do_reset();
        run_frame(K_TOPW, 3, 7, 1'b0);
        do_reset();
        run_frame(K_WHITE, 3, 0, 1'b0);
        idle(8);

        do_reset();
        run_frame(K_R16, 3, 0, 1'b0);
        idle(8);

        do_reset();
        run_frame(K_R8, 3, 0, 1'b0);
        idle(8);

        do_reset();
        run_frame(K_R7, 3, 0, 1'b0);
        idle(8);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_top.md
SOBEL_TOP -- requirements
Module: sobel_top

Interface
REQ-001 Parameter IMG_WIDTH, default 8, pixels per image line (range 4..2048).
REQ-002 Parameter THRESHOLD, default 64, edge-magnitude threshold for the binary output.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst_p, input, 1 bit: asynchronous, active-low reset. The name is kept for codebase compatibility; the reset is asserted when the signal is 0.
REQ-005 Port rgb_enable, input, 1 bit: rgb_data_in holds a valid pixel this cycle.
REQ-006 Port rgb_data_in, input, 24 bits: pixel in raster order; R=[23:16], G=[15:8], B=[7:0].
REQ-007 Port sobel_data_out, output, 24 bits: binary edge pixel; 24'hFFFFFF means edge, 24'h000000 means no edge.
REQ-008 Port sobel_mag, output, 8 bits: clamped gradient magnitude.
REQ-009 Port sobel_valid, output, 1 bit: sobel_data_out and sobel_mag are valid this cycle.

Function
REQ-010 Stage 1 SHALL register gray = (77*R + 150*G + 29*B) >> 8 when rgb_enable=1, using a 16-bit unsigned intermediate. White (FFFFFF) gives 255; black gives 0.
REQ-011 A column counter SHALL advance once per accepted pixel: 0..IMG_WIDTH-1, then wrap to 0.
REQ-012 A row counter SHALL increment on each column wrap and saturate at 2.
REQ-013 Two line buffers of IMG_WIDTH x 8 bits SHALL hold the previous two gray lines. They shift only on a valid stage-1 pixel.
REQ-014 The 3x3 window SHALL shift left by one column per valid stage-1 pixel. Its new right column is {line2 output, line1 output, current gray}, ordered top to bottom.
REQ-015 The window SHALL be marked complete when the row counter is 2 and the column index of the newest pixel is at least 2.
REQ-016 Stage 3 SHALL register Gx = (right column − left column), weighted 1,2,1 top to bottom.
REQ-017 Stage 3 SHALL register Gy = (bottom row − top row), weighted 1,2,1 left to right.
REQ-018 Gx and Gy SHALL be 11-bit signed values (range ±1020).
REQ-019 Stage 4 SHALL register mag = |Gx| + |Gy|, clamped to 255.
REQ-020 Stage 5 SHALL register the outputs:
- sobel_mag = mag.
- sobel_data_out = 24'hFFFFFF if mag >= THRESHOLD, else 24'h000000.
REQ-021 Latency: a pixel sampled at edge N with a complete window SHALL produce sobel_valid=1 after edge N+4.
REQ-022 Throughput: one pixel per cycle.
REQ-023 A valid flag SHALL travel with every pipeline stage; stages advance every cycle regardless of rgb_enable.
REQ-024 rgb_enable=0 SHALL insert a bubble: no counter, window or buffer change, and sobel_valid=0 four cycles later.
REQ-025 Border pixels (first two rows of the stream, first two columns of each row) SHALL produce no output.
REQ-026 When sobel_valid=0, the data outputs SHALL hold their last value.

Reset
REQ-027 rst_p=0 SHALL immediately clear:
- counters, window, stage registers and all valid flags;
- sobel_data_out=0, sobel_mag=0, sobel_valid=0.
REQ-028 Line-buffer contents need not be cleared; the row counter gates validity.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight pixels.
REQ-030 After reset release, the first accepted pixel SHALL be treated as row 0, column 0.

Structure
REQ-031 A shared package sobel_pkg SHALL hold:
- the gray coefficients 77/150/29;
- gradient width 11;
- magnitude clamp 255;
- pipeline latency 4.
REQ-032 Line storage SHALL be one sub-module, sobel_line_buffer: a parameterised-depth 8-bit shift FIFO with a shift-enable input, instantiated twice.
REQ-033 All other logic (gray conversion, counters, window, gradients, magnitude, threshold) SHALL reside in sobel_top.

Verification
REQ-034 Reset then 24 white pixels (IMG_WIDTH=8) -> exactly 6 valid outputs, the first 4 cycles after the 19th pixel, each with sobel_mag=0 and sobel_data_out=000000.
REQ-035 Rows with columns 0-3 white and columns 4-7 black, 3 rows -> valid outputs for columns 2..7 of row 2: sobel_mag = 0, 0, 255, 255, 0, 0; data_out FFFFFF only at columns 4 and 5.
REQ-036 8 white pixels, then 16 black pixels -> row-2 outputs have sobel_mag = 255 (Gy = −1020, clamped) and data_out FFFFFF.
REQ-037 Input stream with rgb_enable toggling every cycle -> outputs identical in value and order to the contiguous stream, with sobel_valid gaps matching the input gaps.
REQ-038 rst_p pulsed low mid-row -> all outputs 0 immediately; no valid output until two new full rows plus 3 pixels have been accepted.
REQ-039 Horizontal ramp (gray step of 16 per column), THRESHOLD=64 -> sobel_mag=128 and data_out=FFFFFF for every valid output.
